muldiv_ctrl: RTL and testbench
==============================

Name: muldiv_ctrl

Overview:
- Sequencer for the EXE-stage multiplier IP (fixed-latency, pipelined) and divider IP (stream handshake, variable latency).
- Latches operands and sign-extends them to 33 bits. Drives the IP inputs, then captures HI/LO results.
- Raises a one-cycle done pulse that EXE uses for its over/stall logic.
- Cancels cleanly on an exception flush; any divide already in flight inside the IP is drained.

Parameters:
MUL_LAT, 2, multiplier IP pipeline depth in cycles (must be >= 1)
CNT_W, 3, width of the multiply latency counter (2^CNT_W > MUL_LAT)

Ports:
clk  in  1  system clock, rising edge
resetn  in  1  asynchronous active-low reset
op_valid  in  1  EXE holds a valid mul/div instruction
op_mul  in  1  instruction is MULT/MULTU
op_div  in  1  instruction is DIV/DIVU
op_signed  in  1  1 = signed variant, 0 = unsigned
src1  in  32  rs operand (multiplicand / dividend)
src2  in  32  rt operand (multiplier / divisor)
cancel  in  1  exception/eret flush of EXE
mul_a  out  33  multiplier IP operand A (registered)
mul_b  out  33  multiplier IP operand B (registered)
mul_p  in  66  multiplier IP product
div_dividend  out  33  divider IP dividend (registered)
div_divisor  out  33  divider IP divisor (registered)
div_in_valid  out  1  divider input tvalid (dividend and divisor share it)
div_in_ready  in  1  divider input tready
div_out_valid  in  1  divider output tvalid
div_out  in  80  divider output: quotient [71:40], remainder [31:0]
busy  out  1  controller is not in IDLE
done  out  1  one-cycle pulse: hi_out/lo_out are valid
hi_out  out  32  HI result (product[63:32] or remainder)
lo_out  out  32  LO result (product[31:0] or quotient)

Behaviour:
- Reset (resetn=0, takes effect asynchronously):
  - state=IDLE; counter=0.
  - All operand registers, hi_out, lo_out = 0.
  - div_in_valid=0, busy=0, done=0.
  - Reset mid-operation abandons the operation. The IP is assumed to be reset alongside.
- States: IDLE, MUL_WAIT, DIV_SEND, DIV_WAIT, DIV_DRAIN, DONE.
- Accept: in IDLE, when op_valid & (op_mul|op_div) & ~cancel.
  - Latch {op_signed?src1[31]:0, src1} and {op_signed?src2[31]:0, src2} into the selected operand pair.
  - op_mul and op_div both set: op_mul wins.
- Multiply path: IDLE -> MUL_WAIT with counter=0.
  - Counter increments each cycle.
  - When counter==MUL_LAT-1: capture mul_p[63:32] into hi_out and mul_p[31:0] into lo_out; go to DONE.
  - Accept in cycle T gives done in cycle T+MUL_LAT+1 (T+3 at default).
- Divide path, zero divisor: if the latched src2==0, skip the IP and go straight to DONE next cycle.
  - hi_out=src1, lo_out=32'hFFFFFFFF.
  - This is the defined result for an architecturally undefined case.
- Divide path, normal: IDLE -> DIV_SEND.
  - DIV_SEND: div_in_valid=1 and held until a cycle with div_in_ready=1, then go to DIV_WAIT. div_in_valid drops the next cycle.
  - DIV_WAIT: on div_out_valid, capture hi_out=div_out[31:0] and lo_out=div_out[71:40]; go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE. hi_out/lo_out hold until the next capture.
  - No new op is accepted in DONE. The EXE instruction advances during the DONE cycle, so the next op_valid seen in IDLE belongs to the next instruction.
- busy = (state!=IDLE) & (state!=DONE).
- Cancel handling: cancel has priority over every other event.
  - IDLE, MUL_WAIT, DONE -> IDLE next cycle; no done; results not updated.
  - DIV_SEND with handshake not yet completed -> IDLE; div_in_valid drops.
  - DIV_SEND with handshake completing in the same cycle, or DIV_WAIT without div_out_valid -> DIV_DRAIN.
  - DIV_DRAIN: busy=1, done=0. On div_out_valid, discard the result and go to IDLE.
  - DIV_WAIT with div_out_valid in the same cycle as cancel -> IDLE; result discarded.
  - A new op seen during DIV_DRAIN is not accepted. EXE stalls on busy.
- op_valid deasserted while in any wait state has no effect; only cancel aborts an operation.

Test Plan:
- MULT signed: src1=32'hFFFFFFFE (-2), src2=3 -> mul_a=33'h1FFFFFFFE; done at T+3; hi_out=FFFFFFFF, lo_out=FFFFFFFA.
- MULTU: src1=FFFFFFFF, src2=FFFFFFFF -> done at T+3; hi_out=FFFFFFFE, lo_out=00000001.
- DIV signed: src1=-7 (FFFFFFF9), src2=2; div_in_ready low for 3 cycles, div_out_valid 10 cycles later with div_out quotient field FFFFFFFD and remainder field FFFFFFFF.
  - div_in_valid must be held for those 3 cycles.
  - Required result: hi_out=FFFFFFFF, lo_out=FFFFFFFD, one done pulse.
- Zero divisor: DIVU src1=1234, src2=0 -> div_in_valid never rises; done at T+2; hi_out=00001234, lo_out=FFFFFFFF.
- Cancel in DIV_WAIT: busy stays 1 until the late div_out_valid; no done pulse; hi_out/lo_out keep their previous values.
  - A MULT issued after busy drops then completes normally.
- resetn pulsed low in MUL_WAIT -> state IDLE; busy, done, hi_out, lo_out = 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: sequences the fixed-latency multiplier IP and the stream divider IP for EXE,
// capturing HI/LO and pulsing done; flushes abort, draining any divide already inside the IP.
module muldiv_ctrl #(
  parameter int MUL_LAT = 2,
  parameter int CNT_W   = 3
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        op_valid,
  input  logic        op_mul,
  input  logic        op_div,
  input  logic        op_signed,
  input  logic [31:0] src1,
  input  logic [31:0] src2,
  input  logic        cancel,
  output logic [32:0] mul_a,
  output logic [32:0] mul_b,
  input  logic [65:0] mul_p,
  output logic [32:0] div_dividend,
  output logic [32:0] div_divisor,
  output logic        div_in_valid,
  input  logic        div_in_ready,
  input  logic        div_out_valid,
  input  logic [79:0] div_out,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out
);
  typedef enum logic [2:0] {IDLE, MUL_WAIT, DIV_SEND, DIV_WAIT, DIV_DRAIN, DONE} state_t;
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [32:0] mul_a_q, mul_a_d, mul_b_q, mul_b_d;
  logic [32:0] div_dividend_q, div_dividend_d, div_divisor_q, div_divisor_d;
  logic div_in_valid_q, div_in_valid_d, busy_q, busy_d, done_q, done_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic accept, hs, div_zero;
  logic [32:0] ext1, ext2;
  logic unused_bits;
  assign unused_bits = ^{mul_p[65:64], div_out[79:72], div_out[39:32]};
  assign accept = op_valid & (op_mul | op_div) & ~cancel;
  assign ext1 = {op_signed & src1[31], src1};
  assign ext2 = {op_signed & src2[31], src2};
  assign hs = div_in_valid_q & div_in_ready;
  assign div_zero = div_divisor_q[31:0] == 32'd0;
  always_comb begin
    state_d = state_q;
    cnt_d = '0;
    mul_a_d = mul_a_q;
    mul_b_d = mul_b_q;
    div_dividend_d = div_dividend_q;
    div_divisor_d = div_divisor_q;
    div_in_valid_d = 1'b0;
    hi_d = hi_q;
    lo_d = lo_q;
    case (state_q)
      IDLE: begin
        if (accept && op_mul) begin
          mul_a_d = ext1;
          mul_b_d = ext2;
          state_d = MUL_WAIT;
        end else if (accept) begin
          div_dividend_d = ext1;
          div_divisor_d = ext2;
          div_in_valid_d = |src2;
          state_d = DIV_SEND;
        end
      end
      MUL_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (cancel) state_d = IDLE;
        else if (cnt_q == CNT_W'(MUL_LAT - 1)) begin
          hi_d = mul_p[63:32];
          lo_d = mul_p[31:0];
          state_d = DONE;
        end
      end
      DIV_SEND: begin
        if (cancel) state_d = hs ? DIV_DRAIN : IDLE;
        else if (div_zero) begin
          hi_d = div_dividend_q[31:0];
          lo_d = 32'hFFFF_FFFF;
          state_d = DONE;
        end else if (div_in_ready) state_d = DIV_WAIT;
        else div_in_valid_d = 1'b1;
      end
      DIV_WAIT: begin
        if (cancel) state_d = div_out_valid ? IDLE : DIV_DRAIN;
        else if (div_out_valid) begin
          hi_d = div_out[31:0];
          lo_d = div_out[71:40];
          state_d = DONE;
        end
      end
      DIV_DRAIN: state_d = div_out_valid ? IDLE : DIV_DRAIN;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE) && (state_d != DONE);
    done_d = state_d == DONE;
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      cnt_q <= '0;
      mul_a_q <= '0;
      mul_b_q <= '0;
      div_dividend_q <= '0;
      div_divisor_q <= '0;
      div_in_valid_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      mul_a_q <= mul_a_d;
      mul_b_q <= mul_b_d;
      div_dividend_q <= div_dividend_d;
      div_divisor_q <= div_divisor_d;
      div_in_valid_q <= div_in_valid_d;
      busy_q <= busy_d;
      done_q <= done_d;
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end
  assign mul_a = mul_a_q;
  assign mul_b = mul_b_q;
  assign div_dividend = div_dividend_q;
  assign div_divisor = div_divisor_q;
  assign div_in_valid = div_in_valid_q;
  assign busy = busy_q;
  assign done = done_q;
  assign hi_out = hi_q;
  assign lo_out = lo_q;
endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb_muldiv_ctrl: directed vectors for muldiv_ctrl with a behavioural multiplier and a hand-driven divider stream.
module tb_muldiv_ctrl;
  logic clk = 1'b0, resetn = 1'b0;
  logic op_valid = 0, op_mul = 0, op_div = 0, op_signed = 0, cancel = 0;
  logic [31:0] src1 = '0, src2 = '0;
  logic [32:0] mul_a, mul_b, div_dividend, div_divisor;
  logic [65:0] mul_p;
  logic div_in_valid, div_in_ready = 0, div_out_valid = 0;
  logic [79:0] div_out = '0;
  logic busy, done;
  logic [31:0] hi_out, lo_out;
  logic signed [65:0] sa, sb;
  int n_vec = 0, n_err = 0;
  always #5 clk = ~clk;
  assign sa = {{33{mul_a[32]}}, mul_a};
  assign sb = {{33{mul_b[32]}}, mul_b};
  assign mul_p = sa * sb;
  muldiv_ctrl dut (
    .clk(clk), .resetn(resetn), .op_valid(op_valid), .op_mul(op_mul), .op_div(op_div),
    .op_signed(op_signed), .src1(src1), .src2(src2), .cancel(cancel),
    .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p),
    .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_in_valid(div_in_valid), .div_in_ready(div_in_ready),
    .div_out_valid(div_out_valid), .div_out(div_out),
    .busy(busy), .done(done), .hi_out(hi_out), .lo_out(lo_out)
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic issue(input logic m, input logic d, input logic s, input logic [31:0] a, input logic [31:0] b);
    op_valid = 1; op_mul = m; op_div = d; op_signed = s; src1 = a; src2 = b;
    tick;
    op_valid = 0; op_mul = 0; op_div = 0;
  endtask
  initial begin
    #3;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_hi", hi_out, 0);
    check("rst_lo", lo_out, 0);
    check("rst_dvalid", div_in_valid, 0);
    #9 resetn = 1;
    tick;
    issue(1, 0, 1, 32'hFFFF_FFFE, 32'd3);
    check("mult_a", mul_a, 33'h1_FFFF_FFFE);
    check("mult_b", mul_b, 33'h0_0000_0003);
    check("mult_busy", busy, 1);
    tick;
    check("mult_done_early", done, 0);
    tick;
    check("mult_done", done, 1);
    check("mult_hi", hi_out, 32'hFFFF_FFFF);
    check("mult_lo", lo_out, 32'hFFFF_FFFA);
    check("mult_busy_done", busy, 0);
    tick;
    check("mult_done_once", done, 0);
    issue(1, 1, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("multu_a", mul_a, 33'h0_FFFF_FFFF);
    check("multu_mulwins", div_in_valid, 0);
    tick;
    tick;
    check("multu_done", done, 1);
    check("multu_hi", hi_out, 32'hFFFF_FFFE);
    check("multu_lo", lo_out, 32'h0000_0001);
    tick;
    issue(0, 1, 1, 32'hFFFF_FFF9, 32'd2);
    check("div_dividend", div_dividend, 33'h1_FFFF_FFF9);
    check("div_divisor", div_divisor, 33'h0_0000_0002);
    check("div_valid1", div_in_valid, 1);
    tick;
    check("div_valid2", div_in_valid, 1);
    tick;
    check("div_valid3", div_in_valid, 1);
    tick;
    div_in_ready = 1;
    check("div_valid4", div_in_valid, 1);
    tick;
    div_in_ready = 0;
    check("div_valid_drop", div_in_valid, 0);
    check("div_wait_busy", busy, 1);
    repeat (9) tick;
    check("div_wait_nodone", done, 0);
    div_out_valid = 1;
    div_out = {8'h00, 32'hFFFF_FFFD, 8'h00, 32'hFFFF_FFFF};
    tick;
    div_out_valid = 0;
    check("div_done", done, 1);
    check("div_hi", hi_out, 32'hFFFF_FFFF);
    check("div_lo", lo_out, 32'hFFFF_FFFD);
    tick;
    check("div_done_once", done, 0);
    issue(0, 1, 0, 32'h0000_1234, 32'd0);
    check("dz_novalid", div_in_valid, 0);
    check("dz_busy", busy, 1);
    tick;
    check("dz_done", done, 1);
    check("dz_hi", hi_out, 32'h0000_1234);
    check("dz_lo", lo_out, 32'hFFFF_FFFF);
    check("dz_novalid2", div_in_valid, 0);
    tick;
    issue(0, 1, 0, 32'd100, 32'd7);
    check("cx_valid", div_in_valid, 1);
    div_in_ready = 1;
    tick;
    div_in_ready = 0;
    check("cx_sent", div_in_valid, 0);
    cancel = 1;
    tick;
    cancel = 0;
    check("cx_drain_busy", busy, 1);
    check("cx_drain_nodone", done, 0);
    repeat (4) tick;
    check("cx_drain_busy2", busy, 1);
    div_out_valid = 1;
    div_out = {8'h00, 32'd14, 8'h00, 32'd2};
    tick;
    div_out_valid = 0;
    check("cx_idle", busy, 0);
    check("cx_nodone", done, 0);
    check("cx_hi_kept", hi_out, 32'h0000_1234);
    check("cx_lo_kept", lo_out, 32'hFFFF_FFFF);
    issue(1, 0, 0, 32'd7, 32'd6);
    tick;
    tick;
    check("post_done", done, 1);
    check("post_hi", hi_out, 32'd0);
    check("post_lo", lo_out, 32'd42);
    tick;
    issue(1, 0, 0, 32'd3, 32'd5);
    check("ar_busy_pre", busy, 1);
    #1 resetn = 0;
    #1;
    check("ar_busy", busy, 0);
    check("ar_done", done, 0);
    check("ar_hi", hi_out, 0);
    check("ar_lo", lo_out, 0);
    check("ar_mul_a", mul_a, 0);
    #1 resetn = 1;
    tick;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
